// File: rtl/reg_shadow_bank_pkg.sv
// Shared types and constants for the shadowed register bank: error bit
// positions, staging FSM encoding and the index-width helper.
package reg_shadow_bank_pkg;

  // Error register layout; the error register sits at offset pNUM_REGS.
  localparam int ERR_W        = 3;
  localparam int ERR_ABORT    = 0;
  localparam int ERR_RO_WRITE = 1;
  localparam int ERR_RANGE    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } stage_state_e;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : reg_shadow_bank_pkg

// File: rtl/reg_shadow_bank_if.sv
// USB register bus: byte-wide address/bytecnt/data with read and write strobes.
interface reg_shadow_bank_if #(
  parameter int pBYTECNT_SIZE = 7
);

  logic [7:0]               reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic [7:0]               reg_datai;
  logic [7:0]               reg_datao;
  logic                     reg_read;
  logic                     reg_write;

  modport master (
    output reg_address, reg_bytecnt, reg_datai, reg_read, reg_write,
    input  reg_datao
  );

  modport slave (
    input  reg_address, reg_bytecnt, reg_datai, reg_read, reg_write,
    output reg_datao
  );

endinterface : reg_shadow_bank_if

// File: rtl/reg_stage_fsm.sv
// Collects the bytes of one multi-byte register write and hands back a whole
// word for an atomic commit; any out-of-sequence register write aborts.
module reg_stage_fsm
  import reg_shadow_bank_pkg::*;
#(
  parameter int pREG_BYTES = 4,
  parameter int IDX_W      = 3,
  parameter int BI_W       = idx_width(pREG_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    reg_wr_i,
  input  logic                    wr_ok_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [BI_W-1:0]         wr_byte_i,
  input  logic [7:0]              wr_data_i,
  output logic                    abort_o,
  output logic                    commit_o,
  output logic [IDX_W-1:0]        commit_idx_o,
  output logic [pREG_BYTES*8-1:0] commit_word_o
);

  localparam int              W    = pREG_BYTES * 8;
  localparam logic [BI_W-1:0] LAST = BI_W'(pREG_BYTES - 1);

  stage_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BI_W-1:0]  n_q, n_d;
  logic [W-1:0]     stage_q, stage_d;
  logic [W-1:0]     merged;
  logic [W-1:0]     fresh;
  logic             start;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      stage_q <= stage_d;
    end
  end

  // NOTE: every variable gets a default first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    n_d           = n_q;
    stage_d       = stage_q;
    abort_o       = 1'b0;
    commit_o      = 1'b0;
    commit_idx_o  = wr_idx_i;
    start         = 1'b0;
    merged        = stage_q;
    merged[{wr_byte_i, 3'b000} +: 8] = wr_data_i;
    fresh         = W'(wr_data_i);
    commit_word_o = merged;

    case (state_q)
      ST_IDLE: start = 1'b1;
      ST_FILL: begin
        if (reg_wr_i) begin
          if (wr_ok_i && (wr_idx_i == idx_q) && (wr_byte_i == n_q)) begin
            if (n_q == LAST) begin
              commit_o     = 1'b1;
              commit_idx_o = idx_q;
              state_d      = ST_IDLE;
              n_d          = '0;
              stage_d      = '0;
            end else begin
              stage_d = merged;
              n_d     = n_q + BI_W'(1);
            end
          end else begin
            // Discard the partial word, then let this beat start afresh.
            abort_o = 1'b1;
            state_d = ST_IDLE;
            n_d     = '0;
            stage_d = '0;
            start   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start && wr_ok_i && (wr_byte_i == '0)) begin
      if (LAST == '0) begin
        commit_o      = 1'b1;
        commit_word_o = fresh;
      end else begin
        state_d = ST_FILL;
        idx_d   = wr_idx_i;
        n_d     = BI_W'(1);
        stage_d = fresh;
      end
    end
  end

endmodule : reg_stage_fsm

// File: rtl/reg_shadow_bank.sv
// Bank of multi-byte control registers with atomic staged writes, snapshotted
// read-only status registers, self-clearing pulse registers and a W1C error register.
module reg_shadow_bank
  import reg_shadow_bank_pkg::*;
#(
  parameter int                              pBYTECNT_SIZE = 7,
  parameter int                              pNUM_REGS     = 8,
  parameter int                              pREG_BYTES    = 4,
  parameter logic [7:0]                      pBASE_ADDR    = 8'h60,
  parameter logic [pNUM_REGS-1:0]            pRO_MASK      = '0,
  parameter logic [pNUM_REGS-1:0]            pPULSE_MASK   = '0,
  parameter logic [pNUM_REGS*pREG_BYTES*8-1:0] pRESET_VAL  = '0
) (
  input  logic                                clk_usb,
  input  logic                                reset_n,
  reg_shadow_bank_if.slave                    bus,
  input  logic [pNUM_REGS*pREG_BYTES*8-1:0]   stat_i,
  output logic [pNUM_REGS*pREG_BYTES*8-1:0]   ctrl_o,
  output logic [pNUM_REGS-1:0]                commit_o,
  output logic [ERR_W-1:0]                    err_o
);

  localparam int                       W       = pREG_BYTES * 8;
  localparam int                       IDX_W   = idx_width(pNUM_REGS);
  localparam int                       BI_W    = idx_width(pREG_BYTES);
  localparam logic [7:0]               NUM_C   = 8'(pNUM_REGS);
  localparam logic [pBYTECNT_SIZE-1:0] BYTES_C = pBYTECNT_SIZE'(pREG_BYTES);

  logic [W-1:0]           live_q [pNUM_REGS];
  logic [W-1:0]           snap_q [pNUM_REGS];
  logic [W-1:0]           stat_w [pNUM_REGS];
  logic [pNUM_REGS-1:0]   commit_q, commit_d;
  logic [ERR_W-1:0]       err_q, err_d, err_set, err_clr;
  logic [7:0]             datao_q, rd_byte_d;

  logic [7:0]             offset;
  logic                   is_reg_addr, is_err_addr, is_ro, byte_ok;
  logic [IDX_W-1:0]       idx;
  logic [BI_W-1:0]        byte_idx;
  logic                   reg_wr, wr_ok, ro_wr, rng_wr, snap_en;
  logic [W-1:0]           rd_word;

  logic                   fsm_abort, fsm_commit;
  logic [IDX_W-1:0]       fsm_commit_idx;
  logic [W-1:0]           fsm_commit_word;

  for (genvar k = 0; k < pNUM_REGS; k++) begin : g_slice
    assign ctrl_o[k*W +: W] = live_q[k];
    assign stat_w[k]        = stat_i[k*W +: W];
  end

  // Address decode: offset wraps in 8 bits, so addresses below the base fall outside.
  always_comb begin
    offset      = bus.reg_address - pBASE_ADDR;
    is_reg_addr = (offset < NUM_C);
    is_err_addr = (offset == NUM_C);
    idx         = offset[IDX_W-1:0];
    byte_idx    = bus.reg_bytecnt[BI_W-1:0];
    byte_ok     = (bus.reg_bytecnt < BYTES_C);
    is_ro       = is_reg_addr && pRO_MASK[idx];
    reg_wr      = bus.reg_write && is_reg_addr;
    wr_ok       = reg_wr && !is_ro && byte_ok;
    ro_wr       = reg_wr && is_ro;
    rng_wr      = reg_wr && !byte_ok;
    snap_en     = bus.reg_read && is_ro && (bus.reg_bytecnt == '0);
  end

  reg_stage_fsm #(
    .pREG_BYTES (pREG_BYTES),
    .IDX_W      (IDX_W),
    .BI_W       (BI_W)
  ) u_stage (
    .clk           (clk_usb),
    .rst_n         (reset_n),
    .reg_wr_i      (reg_wr),
    .wr_ok_i       (wr_ok),
    .wr_idx_i      (idx),
    .wr_byte_i     (byte_idx),
    .wr_data_i     (bus.reg_datai),
    .abort_o       (fsm_abort),
    .commit_o      (fsm_commit),
    .commit_idx_o  (fsm_commit_idx),
    .commit_word_o (fsm_commit_word)
  );

  always_comb begin
    err_set             = '0;
    err_set[ERR_ABORT]    = fsm_abort;
    err_set[ERR_RO_WRITE] = ro_wr;
    err_set[ERR_RANGE]    = rng_wr;
    err_clr = (bus.reg_write && is_err_addr) ? bus.reg_datai[ERR_W-1:0] : '0;
    err_d   = (err_q & ~err_clr) | err_set;

    commit_d = '0;
    if (fsm_commit) commit_d[fsm_commit_idx] = 1'b1;
  end

  // Byte 0 of a read-only register comes straight from stat_i; later bytes
  // come from the snapshot taken by that same byte-0 read.
  always_comb begin
    rd_word   = '0;
    rd_byte_d = '0;
    if (is_reg_addr) begin
      if (is_ro) rd_word = (bus.reg_bytecnt == '0) ? stat_w[idx] : snap_q[idx];
      else       rd_word = live_q[idx];
    end
    if (bus.reg_read) begin
      if (is_err_addr)                rd_byte_d = {5'b00000, err_q};
      else if (is_reg_addr && byte_ok) rd_byte_d = rd_word[{byte_idx, 3'b000} +: 8];
    end
  end

  // NOTE: the snapshot array is reset along with the live registers; it is
  // tiny, and a defined value keeps reads before the first capture deterministic.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < pNUM_REGS; k++) begin
        live_q[k] <= pRESET_VAL[k*W +: W];
        snap_q[k] <= '0;
      end
      commit_q <= '0;
      err_q    <= '0;
      datao_q  <= '0;
    end else begin
      for (int k = 0; k < pNUM_REGS; k++) begin
        if (fsm_commit && (fsm_commit_idx == IDX_W'(k)))
          live_q[k] <= fsm_commit_word;
        else if (commit_q[k] && pPULSE_MASK[k])
          live_q[k] <= pRESET_VAL[k*W +: W];
      end
      if (snap_en) snap_q[idx] <= stat_w[idx];
      commit_q <= commit_d;
      err_q    <= err_d;
      datao_q  <= rd_byte_d;
    end
  end

  assign commit_o      = commit_q;
  assign err_o         = err_q;
  assign bus.reg_datao = datao_q;

endmodule : reg_shadow_bank

// File: tb/tb_reg_shadow_bank.sv
// Directed bench for reg_shadow_bank: reset image, atomic commit, abort,
// pulse, read-only snapshot, range errors and a table of read/write beats.
module tb_reg_shadow_bank;

  localparam int N  = 8;
  localparam int B  = 4;
  localparam int W  = 32;
  localparam int NV = 15;
  localparam logic [N*W-1:0] RESET_VAL = {32'h0, 32'h0, 32'h0, 32'hA0A0A0A0,
                                          32'h0, 32'hDEADBEEF, 32'h12345678, 32'h0};

  logic           clk_usb = 1'b0;
  logic           reset_n = 1'b0;
  logic [N*W-1:0] stat_i;
  logic [N*W-1:0] ctrl_o;
  logic [N-1:0]   commit_o;
  logic [2:0]     err_o;
  int             checks = 0;
  int             errors = 0;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [6:0] bc;
    logic [7:0] din;
    logic [7:0] exp_do;
    logic [7:0] exp_commit;
    logic [2:0] exp_err;
  } vec_t;

  vec_t vecs [NV];

  reg_shadow_bank_if #(.pBYTECNT_SIZE(7)) bus ();

  reg_shadow_bank #(
    .pBYTECNT_SIZE (7),
    .pNUM_REGS     (N),
    .pREG_BYTES    (B),
    .pBASE_ADDR    (8'h60),
    .pRO_MASK      (8'h20),
    .pPULSE_MASK   (8'h10),
    .pRESET_VAL    (RESET_VAL)
  ) dut (
    .clk_usb  (clk_usb),
    .reset_n  (reset_n),
    .bus      (bus),
    .stat_i   (stat_i),
    .ctrl_o   (ctrl_o),
    .commit_o (commit_o),
    .err_o    (err_o)
  );

  always #5 clk_usb = ~clk_usb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slice(input int k);
    return ctrl_o[k*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk_usb);
    #1;
  endtask

  task automatic write_beat(input logic [7:0] a, input logic [6:0] bc, input logic [7:0] d);
    @(negedge clk_usb);
    bus.reg_address = a;
    bus.reg_bytecnt = bc;
    bus.reg_datai   = d;
    bus.reg_write   = 1'b1;
    tick();
    bus.reg_write   = 1'b0;
  endtask

  task automatic read_beat(input logic [7:0] a, input logic [6:0] bc);
    @(negedge clk_usb);
    bus.reg_address = a;
    bus.reg_bytecnt = bc;
    bus.reg_read    = 1'b1;
    tick();
    bus.reg_read    = 1'b0;
  endtask

  initial begin
    //                wr    rd    addr   bc    din    do     commit err
    vecs[0]  = '{1'b1, 1'b0, 8'h60, 7'd0, 8'hA5, 8'h00, 8'h00, 3'b000};
    vecs[1]  = '{1'b1, 1'b0, 8'h60, 7'd1, 8'h5A, 8'h00, 8'h00, 3'b000};
    vecs[2]  = '{1'b1, 1'b0, 8'h60, 7'd2, 8'hC3, 8'h00, 8'h00, 3'b000};
    vecs[3]  = '{1'b1, 1'b0, 8'h60, 7'd3, 8'h3C, 8'h00, 8'h01, 3'b000};
    vecs[4]  = '{1'b0, 1'b1, 8'h60, 7'd0, 8'h00, 8'hA5, 8'h00, 3'b000};
    vecs[5]  = '{1'b0, 1'b1, 8'h60, 7'd3, 8'h00, 8'h3C, 8'h00, 3'b000};
    vecs[6]  = '{1'b0, 1'b1, 8'h62, 7'd0, 8'h00, 8'hEF, 8'h00, 3'b000};
    vecs[7]  = '{1'b0, 1'b1, 8'h62, 7'd3, 8'h00, 8'hDE, 8'h00, 3'b000};
    vecs[8]  = '{1'b0, 1'b1, 8'h62, 7'd4, 8'h00, 8'h00, 8'h00, 3'b000};
    vecs[9]  = '{1'b0, 1'b1, 8'hFF, 7'd0, 8'h00, 8'h00, 8'h00, 3'b000};
    vecs[10] = '{1'b0, 1'b1, 8'h68, 7'd0, 8'h00, 8'h00, 8'h00, 3'b000};
    vecs[11] = '{1'b1, 1'b0, 8'h60, 7'd6, 8'h77, 8'h00, 8'h00, 3'b100};
    vecs[12] = '{1'b0, 1'b1, 8'h68, 7'd0, 8'h00, 8'h04, 8'h00, 3'b100};
    vecs[13] = '{1'b1, 1'b0, 8'h68, 7'd0, 8'h04, 8'h00, 8'h00, 3'b000};
    vecs[14] = '{1'b0, 1'b1, 8'h68, 7'd0, 8'h00, 8'h00, 8'h00, 3'b000};

    bus.reg_address = '0;
    bus.reg_bytecnt = '0;
    bus.reg_datai   = '0;
    bus.reg_read    = 1'b0;
    bus.reg_write   = 1'b0;
    stat_i          = '0;

    // Reset image
    repeat (2) @(negedge clk_usb);
    reset_n = 1'b1;
    #1;
    check("reset slice2", slice(2), 32'hDEADBEEF);
    check("reset slice1", slice(1), 32'h12345678);
    check("reset commit", {24'h0, commit_o}, 32'h0);
    check("reset err", {29'h0, err_o}, 32'h0);
    check("reset datao", {24'h0, bus.reg_datao}, 32'h0);

    // Raise an error, start a fill, then reset asynchronously mid-fill
    write_beat(8'h60, 7'd5, 8'h99);
    check("range err pre-reset", {29'h0, err_o}, 32'h4);
    write_beat(8'h62, 7'd0, 8'h11);
    write_beat(8'h62, 7'd1, 8'h22);
    #2 reset_n = 1'b0;
    #1;
    check("midfill reset slice2", slice(2), 32'hDEADBEEF);
    check("midfill reset commit", {24'h0, commit_o}, 32'h0);
    check("midfill reset err", {29'h0, err_o}, 32'h0);
    @(negedge clk_usb);
    reset_n = 1'b1;
    // A stale FILL(2,2) would commit these two bytes; an idle FSM ignores them
    write_beat(8'h62, 7'd2, 8'h33);
    write_beat(8'h62, 7'd3, 8'h44);
    check("fsm idle after reset slice2", slice(2), 32'hDEADBEEF);
    check("fsm idle after reset commit", {24'h0, commit_o}, 32'h0);
    check("fsm idle after reset err", {29'h0, err_o}, 32'h0);

    // Atomic four-byte write to reg 1
    write_beat(8'h61, 7'd0, 8'h11);
    check("atomic b0 slice1", slice(1), 32'h12345678);
    write_beat(8'h61, 7'd1, 8'h22);
    check("atomic b1 slice1", slice(1), 32'h12345678);
    write_beat(8'h61, 7'd2, 8'h33);
    check("atomic b2 slice1", slice(1), 32'h12345678);
    check("atomic b2 commit", {24'h0, commit_o}, 32'h0);
    write_beat(8'h61, 7'd3, 8'h44);
    check("atomic commit slice1", slice(1), 32'h44332211);
    check("atomic commit pulse", {24'h0, commit_o}, 32'h02);
    tick();
    check("atomic commit drops", {24'h0, commit_o}, 32'h0);
    check("atomic slice1 holds", slice(1), 32'h44332211);

    // Abort a reg 1 fill by starting reg 3
    write_beat(8'h61, 7'd0, 8'hAA);
    write_beat(8'h61, 7'd1, 8'hBB);
    write_beat(8'h63, 7'd0, 8'h77);
    check("abort slice1 unchanged", slice(1), 32'h44332211);
    check("abort err", {29'h0, err_o}, 32'h1);
    check("abort commit", {24'h0, commit_o}, 32'h0);
    write_beat(8'h68, 7'd0, 8'h01);
    check("abort err cleared", {29'h0, err_o}, 32'h0);
    write_beat(8'h63, 7'd1, 8'h66);
    write_beat(8'h63, 7'd2, 8'h55);
    write_beat(8'h63, 7'd3, 8'h44);
    check("refill slice3", slice(3), 32'h44556677);
    check("refill commit", {24'h0, commit_o}, 32'h08);
    check("refill err", {29'h0, err_o}, 32'h0);

    // Pulse register 4
    write_beat(8'h64, 7'd0, 8'h05);
    write_beat(8'h64, 7'd1, 8'h00);
    write_beat(8'h64, 7'd2, 8'h00);
    check("pulse before commit", slice(4), 32'hA0A0A0A0);
    write_beat(8'h64, 7'd3, 8'h00);
    check("pulse value", slice(4), 32'h00000005);
    check("pulse commit", {24'h0, commit_o}, 32'h10);
    tick();
    check("pulse restored", slice(4), 32'hA0A0A0A0);
    check("pulse commit drops", {24'h0, commit_o}, 32'h0);

    // Read-only snapshot on reg 5
    stat_i[5*W +: W] = 32'hA1B2C3D4;
    read_beat(8'h65, 7'd0);
    check("ro byte0", {24'h0, bus.reg_datao}, 32'hD4);
    stat_i[5*W +: W] = 32'h0;
    read_beat(8'h65, 7'd1);
    check("ro byte1", {24'h0, bus.reg_datao}, 32'hC3);
    read_beat(8'h65, 7'd2);
    check("ro byte2", {24'h0, bus.reg_datao}, 32'hB2);
    read_beat(8'h65, 7'd3);
    check("ro byte3", {24'h0, bus.reg_datao}, 32'hA1);
    tick();
    check("datao idle zero", {24'h0, bus.reg_datao}, 32'h0);
    write_beat(8'h65, 7'd0, 8'h12);
    check("ro write err", {29'h0, err_o}, 32'h2);
    check("ro write commit", {24'h0, commit_o}, 32'h0);
    write_beat(8'h68, 7'd0, 8'h07);
    check("err clear all", {29'h0, err_o}, 32'h0);

    // Table of single-cycle beats
    for (int i = 0; i < NV; i++) begin
      @(negedge clk_usb);
      bus.reg_address = vecs[i].addr;
      bus.reg_bytecnt = vecs[i].bc;
      bus.reg_datai   = vecs[i].din;
      bus.reg_write   = vecs[i].wr;
      bus.reg_read    = vecs[i].rd;
      tick();
      bus.reg_write   = 1'b0;
      bus.reg_read    = 1'b0;
      check($sformatf("vec%0d datao", i), {24'h0, bus.reg_datao}, {24'h0, vecs[i].exp_do});
      check($sformatf("vec%0d commit", i), {24'h0, commit_o}, {24'h0, vecs[i].exp_commit});
      check($sformatf("vec%0d err", i), {29'h0, err_o}, {29'h0, vecs[i].exp_err});
    end
    check("table slice0", slice(0), 32'h3CC35AA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_shadow_bank

// File: doc/reg_shadow_bank.md
Name: reg_shadow_bank

Overview:
Parametrised successor to the OpenADC register block: a bank of pNUM_REGS registers, each pREG_BYTES wide, on the standard USB register bus. Multi-byte writes are staged and committed atomically, and read-only status registers are snapshotted so multi-byte reads are coherent. Per-register pulse (self-clearing) and read-only modes are selected by masks, and a sticky error register records bus misuse. It sits beside the main register block in the clk_usb domain and drives capture/trigger control words.

Parameters:
pBYTECNT_SIZE, 7, width of reg_bytecnt
pNUM_REGS, 8, number of registers (1..32)
pREG_BYTES, 4, bytes per register (1..8)
pBASE_ADDR, 8'h60, address of register 0; register k at pBASE_ADDR+k; error register at pBASE_ADDR+pNUM_REGS
pRO_MASK, 0, bit k=1: register k is read-only and reads stat_i slice k
pPULSE_MASK, 0, bit k=1: register k self-clears one cycle after commit
pRESET_VAL, 0, pNUM_REGS*pREG_BYTES*8-bit reset image of all writable registers

Ports:
clk_usb  in  1  register/USB clock; sole clock
reset_n  in  1  asynchronous, active-low reset
reg_address  in  8  register address
reg_bytecnt  in  pBYTECNT_SIZE  byte index within register
reg_datai  in  8  write data
reg_datao  out  8  read data, registered
reg_read  in  1  read strobe
reg_write  in  1  write strobe
ctrl_o  out  pNUM_REGS*pREG_BYTES*8  live register values; slice k = bits [k*W +: W], W=pREG_BYTES*8
stat_i  in  pNUM_REGS*pREG_BYTES*8  status inputs for RO registers (same slicing)
commit_o  out  pNUM_REGS  one-cycle pulse when register k's live value is updated
err_o  out  3  sticky error flags (mirror of error register)

Behaviour:
- Reset (reset_n low, async): live registers = pRESET_VAL slices; staging, snapshot, error flags, commit_o, reg_datao = 0; staging FSM IDLE.
- Staging FSM, states IDLE / FILL(k, next_byte):
  - IDLE: write to writable reg k with bytecnt 0 -> stage byte 0, go FILL(k,1). If pREG_BYTES=1, commit instead (see below), stay IDLE.
  - FILL(k,n): write to reg k, bytecnt n -> stage byte n, n+1. When n=pREG_BYTES-1 -> commit, go IDLE.
  - FILL: write to any other bank address, or to k with bytecnt != n -> abort: discard stage, set err[0], then treat the beat as a fresh IDLE beat (bytecnt 0 restarts).
- Commit:
  - Live register k <= staged word on the cycle after the last-byte write.
  - commit_o[k] high that same cycle.
  - ctrl_o never shows a partially written word.
- Pulse regs: live value returns to its pRESET_VAL slice one cycle after commit. ctrl_o slice is valid for exactly one cycle.
- RO regs:
  - Any write sets err[1]; no state change.
  - Read at bytecnt 0 returns stat_i byte 0 and latches the whole stat_i slice into the snapshot.
  - Reads at bytecnt>0 return snapshot bytes.
- Out-of-range bytecnt (>= pREG_BYTES):
  - Write: ignored, sets err[2], aborts any FILL.
  - Read: returns 0.
- Reads:
  - 1-cycle latency. reg_datao = addressed byte on the cycle after reg_read, 0 when not reading.
  - Writable regs return live value, not staged value.
  - Addresses outside the bank return 0.
  - Reads never disturb FILL.
- Error register: reads {5'b0, err[2:0]}; a write clears bits where reg_datai=1 (W1C). If set and clear coincide, set wins.
- Simultaneous reg_read and reg_write: both are serviced independently.

Decomposition:
- Shared package/include: bank address offsets, error bit indices (ERR_ABORT=0, ERR_RO_WRITE=1, ERR_RANGE=2), state encodings.
- One natural sub-module: reg_stage_fsm (staging FSM + abort/commit logic, parametrised on pREG_BYTES). The bank body instantiates it once.

Test Plan:
- Reset image: pRESET_VAL slice 2 = 32'hDEADBEEF, assert reset_n=0 mid-FILL -> ctrl_o slice 2 = DEADBEEF, FSM IDLE, commit_o=0, err_o=0.
- Atomic write: write 0x11,0x22,0x33,0x44 to reg 1, bytes 0..3 -> ctrl_o slice 1 unchanged until the cycle after byte 3, then 32'h44332211 with commit_o[1] high for one cycle.
- Abort: write reg 1 bytes 0,1, then reg 3 byte 0 -> reg 1 unchanged, err_o[0]=1, reg 3 FILL begins. Write 0x01 to error reg -> err_o[0]=0.
- Pulse: pPULSE_MASK bit 4, full write 32'h5 to reg 4 -> slice 4 = 5 for exactly one cycle, then reset value.
- RO snapshot: stat_i slice 5 = 32'hA1B2C3D4, read byte 0, change stat_i to 0, read bytes 1..3 -> D4, C3, B2, A1. Write to reg 5 -> err_o[1]=1.
- Range/read: write reg 0 bytecnt 6 -> err_o[2]=1, no commit. Read unmapped address 8'hFF -> reg_datao=0 one cycle after reg_read.
